// File: rtl/mem_req_responder.sv
// Arbitrates the IF-stage fetch port and the MEM-stage data port onto one variable-latency
// backing memory; completions are reported with a one-cycle ready pulse per port.
module mem_req_responder #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 63  // must be >= 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    output logic          i_stall,

    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_stall,

    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,

    output logic          err
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StDWait,
        StIWait,
        StDDone,
        StIDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          mem_en_q, mem_en_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    // Saturating so a stuck wait state can never wrap back to a small count.
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                // Data wins: it belongs to the older instruction in the pipeline.
                if (d_req) begin
                    state_d     = StDWait;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d    = StIWait;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = i_addr;
                end
            end
            StDWait, StIWait: begin
                cnt_d = cnt_inc;
                if (mem_valid) begin
                    cnt_d = '0;
                    if (state_q == StDWait) begin
                        if (!mem_wr_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        state_d = StDDone;
                    end else begin
                        i_rdata_d = mem_rdata;
                        state_d   = StIDone;
                    end
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                    if (state_q == StDWait) begin
                        d_rdata_d = '1;
                        state_d   = StDDone;
                    end else begin
                        i_rdata_d = '1;
                        state_d   = StIDone;
                    end
                end
            end
            // One-cycle ready slot; requests still held by the initiator are ignored here.
            StDDone, StIDone: state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign i_ready   = (state_q == StIDone);
    assign d_ready   = (state_q == StDDone);
    assign i_stall   = i_req & ~i_ready;
    assign d_stall   = d_req & ~d_ready;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_req_responder.sv
// Bench for mem_req_responder: a directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model with its own backing-memory image.
module tb_mem_req_responder;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 63;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready, i_stall;
    logic          d_req = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready, d_stall;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_valid = 1'b0;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_i, exp_d;
    logic        exp_err;

    always #5 clk = ~clk;

    mem_req_responder #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .i_stall  (i_stall),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .d_stall  (d_stall),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ctrl"}, {i_ready, d_ready, i_stall, d_stall, mem_en, mem_wr, err}, 0);
    endtask

    // One isolated transaction; cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic run_txn(input bit is_d, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int lat, input logic [15:0] mrdata,
                           output int en_cyc, output int rdy_cyc, output int en_cnt,
                           output int held_bad, output int stall_bad, output logic [15:0] en_addr,
                           output logic en_wr, output logic [15:0] en_wdata);
        logic rdy, stl, o_rdy, o_stl, req_now;
        en_cyc = -1; rdy_cyc = -1; en_cnt = 0; held_bad = 0; stall_bad = 0;
        en_addr = '0; en_wr = 1'b0; en_wdata = '0;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 1; c <= TO + 20; c++) begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (mem_en) begin
                en_cnt++;
                if (en_cyc < 0) begin
                    en_cyc = c; en_addr = mem_addr; en_wr = mem_wr; en_wdata = mem_wdata;
                end
            end
            if (en_cyc >= 0 && rdy_cyc < 0 && (mem_addr !== addr || mem_wr !== (is_d && wr)
                || (is_d && wr && mem_wdata !== wdata)))
                held_bad++;
            rdy   = is_d ? d_ready : i_ready;
            stl   = is_d ? d_stall : i_stall;
            o_rdy = is_d ? i_ready : d_ready;
            o_stl = is_d ? i_stall : d_stall;
            if (rdy_cyc >= 0 && rdy) stall_bad++;
            if (rdy_cyc < 0 && rdy) rdy_cyc = c;
            req_now = (rdy_cyc < 0) || (c <= rdy_cyc + 1);
            if (stl !== (req_now && c != rdy_cyc)) stall_bad++;
            if (o_rdy !== 1'b0 || o_stl !== 1'b0) stall_bad++;
            if (en_cyc >= 0 && lat > 0 && c == en_cyc + lat) begin
                mem_valid = 1'b1; mem_rdata = mrdata;
            end
            if (rdy_cyc >= 0 && c == rdy_cyc + 1) begin
                d_req = 1'b0; i_req = 1'b0;
            end
            if (rdy_cyc >= 0 && c == rdy_cyc + 2) break;
        end
        d_req = 1'b0; i_req = 1'b0; mem_valid = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;       // 0: memory never answers
        logic [15:0] mrdata;
        logic [15:0] exp_data;
        int          exp_rdy;
        bit          exp_err;
    } vec_t;

    vec_t tbl[7];

    // Random-phase state
    logic [15:0] bmem[16];
    logic [15:0] ref_mem[16];
    logic [15:0] r_addr, r_wdata;
    logic        r_wr, exp_en;
    int          free_prev, rdy_port, next_rdy, rdy_last, cur_port, mem_busy, valid_cyc;
    int          i_act, d_act, i_drop_at, d_drop_at;

    function automatic logic [15:0] seed_val(input int a);
        logic [15:0] v;
        v = 16'(a * 4951);
        return v ^ 16'hC0DE;
    endfunction

    initial begin
        int en_c, rdy_c, en_n, hb, sb;
        logic [15:0] ea, ewd;
        logic ew;

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'hA123, 16'hA123, 3, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF, 16'hBEEF, 4, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h0020, 16'h5A5A, 4, 16'h1111, 16'hBEEF, 6, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h0123, 16'h0000, 3, 16'h7E57, 16'h7E57, 5, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 0, 16'h0000, 16'hFFFF, TO + 1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 1, 16'h4321, 16'h4321, 3, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 16'h0046, 16'h0000, 1, 16'h0F0F, 16'h0F0F, 3, 1'b1};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        exp_i = '0; exp_d = '0;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].is_d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].mrdata,
                    en_c, rdy_c, en_n, hb, sb, ea, ew, ewd);
            chk($sformatf("v%0d_ready_cycle", i), rdy_c, tbl[i].exp_rdy);
            chk($sformatf("v%0d_en_cycle", i), en_c, 1);
            chk($sformatf("v%0d_en_count", i), en_n, 1);
            chk($sformatf("v%0d_mem_addr", i), ea, tbl[i].addr);
            chk($sformatf("v%0d_mem_wr", i), ew, tbl[i].is_d & tbl[i].wr);
            if (tbl[i].is_d && tbl[i].wr) chk($sformatf("v%0d_mem_wdata", i), ewd, tbl[i].wdata);
            chk($sformatf("v%0d_held", i), hb, 0);
            chk($sformatf("v%0d_stall_ready", i), sb, 0);
            if (tbl[i].is_d) exp_d = tbl[i].exp_data;
            else             exp_i = tbl[i].exp_data;
            chk($sformatf("v%0d_i_rdata", i), i_rdata, exp_i);
            chk($sformatf("v%0d_d_rdata", i), d_rdata, exp_d);
            chk($sformatf("v%0d_err", i), err, tbl[i].exp_err);
        end

        // Simultaneous requests: data first, fetch accepted in the IDLE cycle after D_DONE.
        begin
            int en1_c, en2_c, dr, ir, pend;
            logic [15:0] en1_a, en2_a;
            en_n = 0; en1_c = -1; en2_c = -1; en1_a = '0; en2_a = '0; dr = -1; ir = -1;
            pend = -1;
            @(negedge clk);
            d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040; i_req = 1'b1; i_addr = 16'h0012;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                mem_valid = 1'b0;
                if (c == pend) begin
                    mem_valid = 1'b1;
                    mem_rdata = (mem_addr == 16'h0040) ? 16'hBEEF : 16'h600D;
                end
                if (mem_en) begin
                    en_n++;
                    if (en_n == 1) begin en1_c = c; en1_a = mem_addr; end
                    if (en_n == 2) begin en2_c = c; en2_a = mem_addr; end
                    pend = c + 1;
                end
                if (d_ready && dr < 0) dr = c;
                if (i_ready && ir < 0) ir = c;
                if (dr >= 0 && c == dr + 1) d_req = 1'b0;
                if (ir >= 0 && c == ir + 1) i_req = 1'b0;
                if (ir >= 0 && c >= ir + 2) break;
            end
            d_req = 1'b0; i_req = 1'b0; mem_valid = 1'b0;
            chk("sim_first_en_cycle", en1_c, 1);
            chk("sim_first_addr", en1_a, 16'h0040);
            chk("sim_d_ready_cycle", dr, 3);
            chk("sim_fetch_en_cycle", en2_c, 5);
            chk("sim_fetch_addr", en2_a, 16'h0012);
            chk("sim_i_ready_cycle", ir, 7);
            chk("sim_en_count", en_n, 2);
            exp_d = 16'hBEEF; exp_i = 16'h600D;
            chk("sim_d_rdata", d_rdata, exp_d);
            chk("sim_i_rdata", i_rdata, exp_i);
        end

        // Stray mem_valid in IDLE must be ignored.
        begin
            int bad;
            bad = 0;
            @(negedge clk);
            mem_valid = 1'b1; mem_rdata = 16'hDEAD;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                mem_valid = 1'b0;
                if (i_ready || d_ready || mem_en) bad++;
            end
            chk("stray_no_activity", bad, 0);
            chk("stray_i_rdata", i_rdata, exp_i);
            chk("stray_d_rdata", d_rdata, exp_d);
            run_txn(1'b0, 1'b0, 16'h0050, 16'h0, 1, 16'h1234, en_c, rdy_c, en_n, hb, sb, ea, ew, ewd);
            chk("stray_next_ready_cycle", rdy_c, 3);
            chk("stray_next_i_rdata", i_rdata, 16'h1234);
            exp_i = 16'h1234;
        end

        // Reset during I_WAIT; the memory's late answer must not complete anything.
        begin
            int bad;
            bad = 0;
            @(negedge clk);
            i_req = 1'b1; i_addr = 16'h0030;
            repeat (2) @(negedge clk);
            rst_n = 1'b0; i_req = 1'b0;
            #1;
            chk_all_zero("midreset");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            mem_valid = 1'b1; mem_rdata = 16'h9999;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                mem_valid = 1'b0;
                if (i_ready || d_ready || mem_en) bad++;
            end
            chk("late_valid_ignored", bad, 0);
            chk("late_i_rdata", i_rdata, 0);
            exp_i = '0; exp_d = '0;
            run_txn(1'b0, 1'b0, 16'h0030, 16'h0, 2, 16'h3030, en_c, rdy_c, en_n, hb, sb, ea, ew, ewd);
            chk("post_reset_ready_cycle", rdy_c, 4);
            chk("post_reset_i_rdata", i_rdata, 16'h3030);
            chk("post_reset_d_rdata", d_rdata, 0);
            chk("post_reset_err", err, 0);
            exp_i = 16'h3030;
        end

        // Randomized traffic against a transaction-level model.
        for (int a = 0; a < 16; a++) begin
            bmem[a] = seed_val(a);
            ref_mem[a] = seed_val(a);
        end
        free_prev = 1; next_rdy = -1; rdy_last = -1; mem_busy = 0; cur_port = 0; valid_cyc = 0;
        i_act = 0; d_act = 0; i_drop_at = -1; d_drop_at = -1;
        r_addr = '0; r_wr = 1'b0; r_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rdy_port = next_rdy;
            next_rdy = -1;
            mem_valid = 1'b0;
            exp_en = (free_prev != 0) && (i_req || d_req);
            chk("r_mem_en", mem_en, exp_en);
            if (exp_en) begin
                cur_port = d_req ? 1 : 0;
                r_addr   = d_req ? d_addr : i_addr;
                r_wr     = d_req && d_wr;
                r_wdata  = d_wdata;
                mem_busy = 1;
                valid_cyc = cyc + int'($urandom_range(1, 4));
            end
            if (mem_busy != 0) begin
                chk("r_mem_addr", mem_addr, r_addr);
                chk("r_mem_wr", mem_wr, r_wr);
                if (r_wr) chk("r_mem_wdata", mem_wdata, r_wdata);
            end
            chk("r_i_ready", i_ready, rdy_port == 0);
            chk("r_d_ready", d_ready, rdy_port == 1);
            chk("r_i_stall", i_stall, i_req && rdy_port != 0);
            chk("r_d_stall", d_stall, d_req && rdy_port != 1);
            if (rdy_port == 0) begin
                exp_i = ref_mem[i_addr[3:0]];
                chk("r_i_rdata", i_rdata, exp_i);
                chk("r_d_rdata_iso", d_rdata, exp_d);
                i_drop_at = cyc + 1;
            end
            if (rdy_port == 1) begin
                if (d_wr) ref_mem[d_addr[3:0]] = d_wdata;
                else      exp_d = ref_mem[d_addr[3:0]];
                chk("r_d_rdata", d_rdata, exp_d);
                chk("r_i_rdata_iso", i_rdata, exp_i);
                d_drop_at = cyc + 1;
            end
            free_prev = ((free_prev != 0) && !exp_en) || (rdy_last >= 0) ? 1 : 0;
            rdy_last  = rdy_port;

            if (mem_busy != 0 && cyc == valid_cyc) begin
                mem_valid = 1'b1;
                if (mem_wr) begin
                    bmem[mem_addr[3:0]] = mem_wdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = bmem[mem_addr[3:0]];
                end
                next_rdy = cur_port;
                mem_busy = 0;
            end else if (mem_busy == 0 && $urandom_range(0, 15) == 0) begin
                mem_valid = 1'b1;
                mem_rdata = 16'($urandom);
            end

            if (i_act != 0 && cyc == i_drop_at) begin
                i_req = 1'b0; i_act = 0;
            end else if (i_act == 0 && cyc > i_drop_at && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_act = 1;
                i_addr = 16'hA500 | 16'($urandom_range(0, 15));
            end
            if (d_act != 0 && cyc == d_drop_at) begin
                d_req = 1'b0; d_act = 0;
            end else if (d_act == 0 && cyc > d_drop_at && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_act = 1;
                d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'hA500 | 16'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
        end
        chk("r_err_clear", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Memory-side responder for the pipelined core's two memory initiators: the IF-stage instruction fetch and the MEM-stage data access.
- Arbitrates both onto one single-port backing memory with variable latency, completed by a mem_valid handshake.
- Returns read data with a one-cycle ready pulse, and drives per-port stall signals that the hazard unit uses to freeze the PC and the pipeline registers.

Parameters:
- AW, 16, address width in bits
- DW, 16, data width in bits
- TIMEOUT, 63, maximum cycles spent in a wait state before the transaction is forced to complete with an error

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request; held stable until i_ready
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched instruction; valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for the fetch port
- i_stall  out  1  i_req & ~i_ready, combinational
- d_req  in  1  data request; held stable until d_ready
- d_wr  in  1  1=write, 0=read; sampled at accept
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for the data port; also pulses for writes
- d_stall  out  1  d_req & ~d_ready, combinational
- mem_en  out  1  one-cycle issue strobe to the backing memory
- mem_wr  out  1  write qualifier, held for the whole transaction
- mem_addr  out  AW  held for the whole transaction
- mem_wdata  out  DW  held for the whole transaction
- mem_rdata  in  DW  backing read data; valid with mem_valid
- mem_valid  in  1  completion from the backing memory (read data or write ack)
- err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including i_rdata and d_rdata.
  - A transaction in flight is abandoned.
- States: IDLE, D_WAIT, I_WAIT, D_DONE, I_DONE.
- IDLE:
  - d_req=1 → D_WAIT. This has priority over i_req because the data access belongs to the older instruction.
  - Else i_req=1 → I_WAIT.
  - Else stay in IDLE.
  - On accept, mem_addr, mem_wr and mem_wdata are registered from the winning port (mem_wr=0 for fetches), and mem_en=1 for exactly the first cycle of the wait state.
- Wait states (*_WAIT):
  - The counter increments every cycle.
  - mem_valid=1 → capture mem_rdata into that port's rdata register and go to *_DONE. For writes, d_rdata is left unchanged.
  - If the counter reaches TIMEOUT without mem_valid: set err=1, load rdata=all ones, go to *_DONE.
  - The counter clears on leaving the wait state.
- *_DONE:
  - The matching ready=1 for exactly this one cycle, then → IDLE.
  - No new request is accepted in DONE. This prevents re-issuing a request that the initiator is still holding during the ready cycle.
- Latency:
  - Request at cycle T (in IDLE) → mem_en at T+1.
  - mem_valid at T+1+k (k≥1) → ready at T+2+k.
  - Minimum is 3 cycles, with mem_valid one cycle after mem_en.
- Stray mem_valid in IDLE or DONE is ignored.
- Simultaneous i_req and d_req: data is served first; fetch is accepted in the IDLE cycle following D_DONE. Fetch starvation is bounded because the MEM stage issues at most one access per instruction.
- Request deasserted mid-transaction (flush):
  - The transaction still completes and ready still pulses. The initiator ignores it.
  - A write already issued is not cancelled.
- Port isolation: i_rdata/d_rdata hold their last captured value between completions; only the serviced port's rdata register changes.
- Arithmetic: the counter is sized ceil(log2(TIMEOUT+1)) bits, saturates at TIMEOUT and never wraps.

Test Plan:
- Single fetch, i_addr=0x0010, mem_valid one cycle after mem_en with rdata=0xA123 → mem_en cycle 1, i_ready cycle 3, i_rdata=0xA123, i_stall=1 for cycles 0–2.
- Simultaneous d_req read (0x0040) and i_req (0x0012) → data issued first; d_ready with 0xBEEF; fetch mem_en exactly 2 cycles after d_ready; i_ready later; d_rdata unchanged by the fetch.
- Store: d_wr=1, d_addr=0x0020, d_wdata=0x5A5A, 4-cycle memory → mem_wr=1, mem_wdata=0x5A5A held until mem_valid; d_ready pulses once; no second mem_en while d_req is still high during DONE.
- Timeout: d_req read with mem_valid never asserted → d_ready after TIMEOUT wait cycles, d_rdata=0xFFFF, err=1 and stays 1 across later good transactions.
- Reset mid-transaction: rst_n=0 during I_WAIT, then mem_valid arrives after release → all outputs 0, state IDLE, the late mem_valid is ignored, the next i_req completes normally.
- Stray mem_valid pulse in IDLE with no requests → no ready, no state change, rdata registers unchanged.
